conv2_ctrl: RTL and testbench

CONV2_CTRL -- requirements
Module: conv2_ctrl

---
 rtl/conv2_ctrl.sv | 141 ++++++++++++++
 tb/tb_conv2_ctrl.sv | 193 +++++++++++++++++++
 2 files changed

// File: rtl/conv2_ctrl.sv
// Pixel-stream controller for a shared conv2 sum unit: tracks the raster position,
// detects completed windows and issues one sum-unit evaluation per output channel.
module conv2_ctrl #(
    parameter int unsigned WIDTH       = 12,
    parameter int unsigned HEIGHT      = 12,
    parameter int unsigned FILTER_SIZE = 5,
    parameter int unsigned NUM_CH      = 3
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       valid_in,
    output logic       in_ready,
    output logic       calc_en,
    output logic [1:0] filt_sel,
    output logic       out_valid,
    output logic [1:0] out_ch,
    output logic [2:0] out_row,
    output logic [2:0] out_col,
    output logic       frame_done
);

    localparam int unsigned COL_W = (WIDTH > 1) ? $clog2(WIDTH) : 1;
    localparam int unsigned ROW_W = (HEIGHT > 1) ? $clog2(HEIGHT) : 1;
    localparam int unsigned CH_W  = 2;
    localparam int unsigned WIN_W = 3;
    localparam int unsigned K_OFF = FILTER_SIZE - 1;

    typedef enum logic [1:0] {
        ST_ACCEPT = 2'd0,
        ST_ISSUE  = 2'd1,
        ST_DONE   = 2'd2
    } state_e;

    state_e             state_q, state_d;
    logic [COL_W-1:0]   col_q, col_d;
    logic [ROW_W-1:0]   row_q, row_d;
    logic [CH_W-1:0]    ch_q, ch_d;
    logic [WIN_W-1:0]   win_row_q, win_row_d;
    logic [WIN_W-1:0]   win_col_q, win_col_d;
    logic               last_q, last_d;
    logic               out_valid_q, out_valid_d;
    logic [CH_W-1:0]    out_ch_q, out_ch_d;
    logic [WIN_W-1:0]   out_row_q, out_row_d;
    logic [WIN_W-1:0]   out_col_q, out_col_d;

    // Next-state, counters and Moore decode of the handshake / issue strobes.
    always_comb begin
        state_d    = state_q;
        col_d      = col_q;
        row_d      = row_q;
        ch_d       = ch_q;
        win_row_d  = win_row_q;
        win_col_d  = win_col_q;
        last_d     = last_q;
        in_ready   = 1'b0;
        calc_en    = 1'b0;
        filt_sel   = '0;
        frame_done = 1'b0;

        case (state_q)
            ST_ACCEPT: begin
                in_ready = 1'b1;
                if (valid_in) begin
                    if (col_q == COL_W'(WIDTH - 1)) begin
                        col_d = '0;
                        row_d = (row_q == ROW_W'(HEIGHT - 1)) ? '0 : row_q + 1'b1;
                    end else begin
                        col_d = col_q + 1'b1;
                    end
                    if ((col_q >= COL_W'(K_OFF)) && (row_q >= ROW_W'(K_OFF))) begin
                        win_col_d = WIN_W'(col_q - COL_W'(K_OFF));
                        win_row_d = WIN_W'(row_q - ROW_W'(K_OFF));
                        last_d    = (col_q == COL_W'(WIDTH - 1)) && (row_q == ROW_W'(HEIGHT - 1));
                        ch_d      = '0;
                        state_d   = ST_ISSUE;
                    end
                end
            end
            ST_ISSUE: begin
                calc_en  = 1'b1;
                filt_sel = ch_q;
                if (ch_q == CH_W'(NUM_CH - 1)) begin
                    ch_d    = '0;
                    state_d = last_q ? ST_DONE : ST_ACCEPT;
                end else begin
                    ch_d = ch_q + 1'b1;
                end
            end
            ST_DONE: begin
                frame_done = 1'b1;
                col_d      = '0;
                row_d      = '0;
                last_d     = 1'b0;
                state_d    = ST_ACCEPT;
            end
            default: state_d = ST_ACCEPT;
        endcase
    end

    // Result tags trail the issue strobe by one cycle, matching the sum-unit latency.
    always_comb begin
        out_valid_d = calc_en;
        out_ch_d    = filt_sel;
        out_row_d   = win_row_q;
        out_col_d   = win_col_q;
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q     <= ST_ACCEPT;
            col_q       <= '0;
            row_q       <= '0;
            ch_q        <= '0;
            win_row_q   <= '0;
            win_col_q   <= '0;
            last_q      <= 1'b0;
            out_valid_q <= 1'b0;
            out_ch_q    <= '0;
            out_row_q   <= '0;
            out_col_q   <= '0;
        end else begin
            state_q     <= state_d;
            col_q       <= col_d;
            row_q       <= row_d;
            ch_q        <= ch_d;
            win_row_q   <= win_row_d;
            win_col_q   <= win_col_d;
            last_q      <= last_d;
            out_valid_q <= out_valid_d;
            out_ch_q    <= out_ch_d;
            out_row_q   <= out_row_d;
            out_col_q   <= out_col_d;
        end
    end

    assign out_valid = out_valid_q;
    assign out_ch    = out_ch_q;
    assign out_row   = out_row_q;
    assign out_col   = out_col_q;

endmodule

// File: tb/tb_conv2_ctrl.sv
// Scoreboard bench for conv2_ctrl: a pixel-position model queues expected strobes and
// results with their cycle stamps; an independent monitor pops and compares them.
module tb_conv2_ctrl;

    localparam int W  = 12;
    localparam int H  = 12;
    localparam int K  = 5;
    localparam int NC = 3;

    logic       clk = 1'b0;
    logic       rst = 1'b1;
    logic       valid_in = 1'b0;
    logic       in_ready, calc_en, out_valid, frame_done;
    logic [1:0] filt_sel, out_ch;
    logic [2:0] out_row, out_col;

    conv2_ctrl #(.WIDTH(W), .HEIGHT(H), .FILTER_SIZE(K), .NUM_CH(NC)) dut (
        .clk(clk), .rst(rst), .valid_in(valid_in), .in_ready(in_ready),
        .calc_en(calc_en), .filt_sel(filt_sel), .out_valid(out_valid),
        .out_ch(out_ch), .out_row(out_row), .out_col(out_col), .frame_done(frame_done)
    );

    always #5 clk = ~clk;

    typedef struct { int cyc; int ch; int row; int col; } exp_t;
    typedef struct { int cyc; int acc; int first_k; bit cont; } frm_t;

    exp_t qc[$];
    exp_t qo[$];
    frm_t qf[$];

    int checks = 0;
    int failures = 0;
    int cyc = 0;
    bit armed = 1'b0;
    bit cont_mode = 1'b1;
    int frames_seen = 0;

    task automatic chk(input string name, input int act, input int exp);
        checks++;
        if (act != exp) begin
            failures++;
            $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(posedge clk) cyc <= cyc + 1;

    // Model: predicts what each accepted pixel (at the upcoming edge) must produce.
    int m_col = 0, m_row = 0, acc_cnt = 0, busy_until = -1, first_k = -1;
    always @(negedge clk) begin
        int k;
        bit last;
        exp_t e;
        frm_t f;
        if (armed) chk("in_ready", int'(in_ready), int'(cyc > busy_until));
        if (rst) begin
            while (qc.size() > 0 && qc[$].cyc > cyc) void'(qc.pop_back());
            while (qo.size() > 0 && qo[$].cyc > cyc) void'(qo.pop_back());
            while (qf.size() > 0 && qf[$].cyc > cyc) void'(qf.pop_back());
            m_col = 0; m_row = 0; acc_cnt = 0; busy_until = cyc; first_k = -1;
        end else if (armed && valid_in && in_ready) begin
            k = cyc + 1;
            acc_cnt++;
            if (acc_cnt == 1) first_k = k;
            if (m_col >= K - 1 && m_row >= K - 1) begin
                last = (m_col == W - 1) && (m_row == H - 1);
                for (int c = 0; c < NC; c++) begin
                    e.ch = c; e.row = m_row - (K - 1); e.col = m_col - (K - 1);
                    e.cyc = k + c;     qc.push_back(e);
                    e.cyc = k + 1 + c; qo.push_back(e);
                end
                busy_until = k + NC - 1 + int'(last);
                if (last) begin
                    f.cyc = k + NC; f.acc = acc_cnt; f.first_k = first_k; f.cont = cont_mode;
                    qf.push_back(f);
                    acc_cnt = 0; first_k = -1;
                end
            end
            if (m_col == W - 1) begin
                m_col = 0;
                m_row = (m_row == H - 1) ? 0 : m_row + 1;
            end else begin
                m_col++;
            end
        end
    end

    // Monitor: compares DUT strobes against the queued expectations.
    int calc_cnt = 0, ov_cnt = 0, first_calc = -1;
    always @(negedge clk) begin
        if (armed) begin
            while (qc.size() > 0 && qc[0].cyc < cyc) begin chk("calc_en_missing", 0, 1); void'(qc.pop_front()); end
            while (qo.size() > 0 && qo[0].cyc < cyc) begin chk("out_valid_missing", 0, 1); void'(qo.pop_front()); end
            while (qf.size() > 0 && qf[0].cyc < cyc) begin chk("frame_done_missing", 0, 1); void'(qf.pop_front()); end

            if (calc_en) begin
                if (calc_cnt == 0) first_calc = cyc;
                calc_cnt++;
                if (qc.size() > 0 && qc[0].cyc == cyc) begin
                    chk("filt_sel", int'(filt_sel), qc[0].ch);
                    void'(qc.pop_front());
                end else chk("calc_en_unexpected", 1, 0);
            end else begin
                chk("filt_sel_idle", int'(filt_sel), 0);
            end

            if (out_valid) begin
                ov_cnt++;
                if (qo.size() > 0 && qo[0].cyc == cyc) begin
                    chk("out_ch", int'(out_ch), qo[0].ch);
                    chk("out_row", int'(out_row), qo[0].row);
                    chk("out_col", int'(out_col), qo[0].col);
                    void'(qo.pop_front());
                end else chk("out_valid_unexpected", 1, 0);
            end

            if (frame_done) begin
                frames_seen++;
                if (qf.size() > 0 && qf[0].cyc == cyc) begin
                    chk("frame_accepts", qf[0].acc, 144);
                    chk("frame_calc_cycles", calc_cnt, 192);
                    chk("frame_out_valid", ov_cnt, 192);
                    if (qf[0].cont) begin
                        chk("first_window_pixel", first_calc - qf[0].first_k, 52);
                        chk("frame_cycles", cyc - qf[0].first_k + 2, 337);
                    end
                    void'(qf.pop_front());
                end else chk("frame_done_unexpected", 1, 0);
                calc_cnt = 0; ov_cnt = 0; first_calc = -1;
            end
        end
        if (rst) begin
            calc_cnt = 0; ov_cnt = 0; first_calc = -1;
        end
    end

    task automatic run_frame(input bit gaps);
        int start = frames_seen;
        int n = 0;
        cont_mode = !gaps;
        while (frames_seen == start && n < 3000) begin
            valid_in = gaps ? ($urandom_range(0, 2) != 0) : 1'b1;
            @(posedge clk); #1;
            n++;
        end
        chk("frame_completed", frames_seen - start, 1);
    endtask

    initial begin
        bit found;
        rst = 1'b1; valid_in = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        chk("rst_in_ready", int'(in_ready), 1);
        chk("rst_calc_en", int'(calc_en), 0);
        chk("rst_out_valid", int'(out_valid), 0);
        chk("rst_frame_done", int'(frame_done), 0);
        chk("rst_filt_sel", int'(filt_sel), 0);
        armed = 1'b1;
        rst = 1'b0;

        run_frame(1'b0);
        run_frame(1'b0);

        // Abort a window in the middle of its issue burst; reset wins over valid_in.
        found = 1'b0;
        valid_in = 1'b1;
        for (int i = 0; i < 500 && !found; i++) begin
            @(posedge clk); #1;
            if (calc_en && filt_sel == 2'd1) found = 1'b1;
        end
        chk("mid_issue_reached", int'(found), 1);
        rst = 1'b1; valid_in = 1'b1;
        @(posedge clk); #1;
        chk("post_rst_calc_en", int'(calc_en), 0);
        chk("post_rst_in_ready", int'(in_ready), 1);
        chk("post_rst_out_valid", int'(out_valid), 0);
        rst = 1'b0;
        run_frame(1'b0);

        run_frame(1'b1);
        valid_in = 1'b0;
        repeat (8) @(posedge clk);
        #1;
        chk("queues_drained", qc.size() + qo.size() + qf.size(), 0);
        chk("frames_total", frames_seen, 4);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
